fetch_queue: RTL

- Owns the instruction-fetch PC and the single port of the unified instruction/data memory.
- Arbitrates the port between MEM-stage data accesses (priority) and instruction prefetch.
- Buffers fetched instructions in a DEPTH-entry FIFO that feeds the IF/ID register.
- Fetch continues around data accesses, so load/store cycles no longer inject a fetch bubble.

---
 rtl/fetch_queue_pkg.sv | 20 ++
 rtl/fetch_queue_fifo.sv | 64 ++++++
 rtl/fetch_queue.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
// NOP encoding, fetch access size, data region base, queue entry layout.
package fetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0033;
    localparam logic [2:0]  FUNCT3_LW     = 3'b010;
    localparam int unsigned DATA_BASE_DEF = 200;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_DATA,
        ARB_FETCH
    } arb_e;

endpackage

// File: rtl/fetch_queue_fifo.sv
// fq_fifo: synchronous FIFO with push, pop, flush and occupancy count.
// Ports: clk, rst (async high), push/wdata, pop/rdata, flush, count.
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_pop, do_push;

    // Pop of an empty FIFO is ignored; a push into a full FIFO is only
    // accepted when the head leaves in the same cycle.
    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PW'(1);
            if (do_pop)  rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= wdata;
    end

    assign rdata = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: owns fetch PC and the shared memory port, prefetches into
// a FIFO feeding IF/ID. Ports: redirect*, instr_*, d_* (MEM stage), mem_*.
// Optional FQ_BYPASS_EN: empty-queue fetch shown at the head same cycle.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 8,
    parameter int          DATA_BASE = DATA_BASE_DEF,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        instr_pop,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count;
    fq_entry_t     head, push_ent;
    logic          space, push, head_vld;
    arb_e          arb;

    // A full queue can still accept a fetch if the head leaves this cycle.
    assign space = (count != CW'(DEPTH)) || instr_pop;

    always_comb begin
        arb = ARB_IDLE;
        if (d_read || d_write)        arb = ARB_DATA;
        else if (!redirect && space)  arb = ARB_FETCH;
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_funct3 = FUNCT3_LW;
        mem_addr   = '0;
        mem_wdata  = '0;
        d_rdata    = '0;
        unique case (arb)
            ARB_DATA: begin
                // Read+write together is a write; load data stays 0.
                mem_read   = d_read && !d_write;
                mem_write  = d_write;
                mem_funct3 = d_funct3;
                mem_addr   = 32'(d_addr[ADDR_W-1:0]) + 32'(DATA_BASE);
                mem_wdata  = d_wdata;
                if (d_read && !d_write) d_rdata = mem_rdata;
            end
            ARB_FETCH: begin
                mem_read = 1'b1;
                mem_addr = 32'(fetch_pc_q[ADDR_W-1:0]);
            end
            default: ;
        endcase
        // Strobes drop with reset so a store in flight is discarded.
        if (rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            d_rdata   = '0;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect)               fetch_pc_d = redirect_pc;
        else if (arb == ARB_FETCH)  fetch_pc_d = fetch_pc_q + 32'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_pc_q <= RESET_PC;
        else     fetch_pc_q <= fetch_pc_d;
    end

    assign push_ent = '{instr: mem_rdata, pc: fetch_pc_q};

`ifdef FQ_BYPASS_EN
    logic byp;
    fq_entry_t fifo_head;
    assign byp  = (arb == ARB_FETCH) && (count == '0);
    // A bypassed word consumed immediately never enters the queue.
    assign push = (arb == ARB_FETCH) && !(byp && instr_pop);
    assign head = byp ? push_ent : fifo_head;
    assign head_vld = (count != '0) || byp;
`else
    fq_entry_t fifo_head;
    assign push = (arb == ARB_FETCH);
    assign head = fifo_head;
    assign head_vld = (count != '0);
`endif

    fq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fq_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_ent),
        .pop   (instr_pop),
        .flush (redirect),
        .rdata (fifo_head),
        .count (count)
    );

    assign instr_valid = head_vld;
    assign instr       = head_vld ? head.instr : NOP_INSTR;
    assign instr_pc    = head_vld ? head.pc : 32'h0;
    assign instr_pc4   = instr_pc + 32'd4;

endmodule
